// File: rtl/cache_pkg.sv
// cache_pkg: shared types and constants for the direct-mapped data cache.
//   cache_state_t  - controller states (IDLE, FILL, WRITE)
//   DEFAULT_WIDTH  - default data/address width
//   DEFAULT_SETS   - default number of lines (power of two, >= 2)
//   INDEX_W/TAG_W  - index/tag widths for the default geometry
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } cache_state_t;

    localparam int unsigned DEFAULT_WIDTH = 32;
    localparam int unsigned DEFAULT_SETS  = 8;
    localparam int unsigned INDEX_W       = $clog2(DEFAULT_SETS);
    localparam int unsigned TAG_W         = DEFAULT_WIDTH - 2 - INDEX_W;

endpackage

// File: rtl/data_cache_array.sv
// data_cache_array: valid/tag/data storage for a direct-mapped cache.
//   clk, rst   - clock; synchronous active-high reset clears all valid bits
//   wr_en      - write valid=1, wr_tag and wr_data into line wr_index
//   rd_index   - combinational read port index
//   rd_valid   - valid bit of the addressed line
//   rd_tag     - tag of the addressed line
//   rd_data    - data word of the addressed line
module data_cache_array #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SETS  = 8,
    parameter int unsigned IDX_W = 3,
    parameter int unsigned TAG_W = 27
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_index,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [IDX_W-1:0] rd_index,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [WIDTH-1:0] rd_data
);

    logic [SETS-1:0]  valid_q;
    logic [TAG_W-1:0] tag_q  [SETS];
    logic [WIDTH-1:0] data_q [SETS];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

    // Tag/data need no reset; a write coinciding with reset is dropped so an
    // abandoned transaction never lands in the array.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            tag_q[wr_index]  <= wr_tag;
            data_q[wr_index] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-through, no-write-allocate data cache
// sitting in the memory stage of a pipeline.
//   clk, rst     - clock; synchronous active-high reset
//   memRead_M    - load request
//   memWrite_M   - store request (wins when both requests are high)
//   ALUResult_M  - byte address, bits [1:0] ignored
//   writeData_M  - store data
//   readData_M   - load data, valid when memRead_M=1 and stall_M=0
//   stall_M      - freeze request; upstream holds inputs stable while high
//   mem_req      - backing-memory request valid
//   mem_we       - backing-memory request is a write
//   mem_addr     - word-aligned backing-memory address
//   mem_wdata    - backing-memory write data
//   mem_ack      - one-cycle completion pulse from backing memory
//   mem_rdata    - backing-memory read data, valid with mem_ack
module data_cache
    import cache_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned SETS  = DEFAULT_SETS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             memRead_M,
    input  logic             memWrite_M,
    input  logic [WIDTH-1:0] ALUResult_M,
    input  logic [WIDTH-1:0] writeData_M,
    output logic [WIDTH-1:0] readData_M,
    output logic             stall_M,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata
);

    localparam int unsigned IDX_W    = $clog2(SETS);
    localparam int unsigned TAG_BITS = WIDTH - 2 - IDX_W;

    cache_state_t state_q, state_d;

    logic [WIDTH-3:0]    req_word_q;
    logic [WIDTH-1:0]    req_wdata_q;
    logic                req_hit_q;
    logic                store_done_q;

    logic [IDX_W-1:0]    cur_index;
    logic [TAG_BITS-1:0] cur_tag;
    logic [IDX_W-1:0]    req_index;
    logic [TAG_BITS-1:0] req_tag;

    logic                rd_valid;
    logic [TAG_BITS-1:0] rd_tag;
    logic [WIDTH-1:0]    rd_data;
    logic                hit;

    logic                arr_we;
    logic [WIDTH-1:0]    arr_wdata;

    logic                unused_addr_lsbs;

    assign unused_addr_lsbs = ^ALUResult_M[1:0];

    assign cur_index = ALUResult_M[IDX_W+1:2];
    assign cur_tag   = ALUResult_M[WIDTH-1:IDX_W+2];
    assign req_index = req_word_q[IDX_W-1:0];
    assign req_tag   = req_word_q[WIDTH-3:IDX_W];

    assign hit       = rd_valid && (rd_tag == cur_tag);

    assign mem_addr  = {req_word_q, 2'b00};
    assign mem_wdata = req_wdata_q;

    data_cache_array #(
        .WIDTH (WIDTH),
        .SETS  (SETS),
        .IDX_W (IDX_W),
        .TAG_W (TAG_BITS)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (arr_we),
        .wr_index (req_index),
        .wr_tag   (req_tag),
        .wr_data  (arr_wdata),
        .rd_index (cur_index),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request address/data/hit are captured when leaving IDLE so the memory
    // interface stays stable for the whole transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_word_q   <= '0;
            req_wdata_q  <= '0;
            req_hit_q    <= 1'b0;
            store_done_q <= 1'b0;
        end else begin
            store_done_q <= (state_q == WRITE) && mem_ack;
            if ((state_q == IDLE) && (state_d != IDLE)) begin
                req_word_q  <= ALUResult_M[WIDTH-1:2];
                req_wdata_q <= writeData_M;
                req_hit_q   <= hit;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        stall_M    = 1'b0;
        readData_M = '0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        arr_we     = 1'b0;
        arr_wdata  = mem_rdata;
        unique case (state_q)
            IDLE: begin
                if (memWrite_M) begin
                    // The completed store is still presented for one cycle
                    // after its ack; let it retire instead of reissuing it.
                    if (!store_done_q) begin
                        stall_M = 1'b1;
                        state_d = WRITE;
                    end
                end else if (memRead_M) begin
                    if (hit) begin
                        readData_M = rd_data;
                    end else begin
                        stall_M = 1'b1;
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                mem_req = 1'b1;
                stall_M = 1'b1;
                if (mem_ack) begin
                    arr_we  = 1'b1;
                    state_d = IDLE;
                end
            end
            WRITE: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                stall_M = 1'b1;
                if (mem_ack) begin
                    arr_we    = req_hit_q;
                    arr_wdata = req_wdata_q;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data and address width.
REQ-002 SHALL have parameter SETS, default 8, number of direct-mapped lines (power of two, one WIDTH-bit word per line).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port memRead_M  input  1  memory-stage load request.
REQ-006 SHALL have port memWrite_M  input  1  memory-stage store request.
REQ-007 SHALL have port ALUResult_M  input  WIDTH  byte address (bits [1:0] ignored).
REQ-008 SHALL have port writeData_M  input  WIDTH  store data.
REQ-009 SHALL have port readData_M  output  WIDTH  load data, valid when memRead_M=1 and stall_M=0.
REQ-010 SHALL have port stall_M  output  1  freeze request to hazard logic; upstream holds all inputs stable while high.
REQ-011 SHALL have port mem_req  output  1  backing-memory request valid.
REQ-012 SHALL have port mem_we  output  1  backing-memory request is a write.
REQ-013 SHALL have port mem_addr  output  WIDTH  word-aligned request address ([1:0]=0).
REQ-014 SHALL have port mem_wdata  output  WIDTH  write data.
REQ-015 SHALL have port mem_ack  input  1  one-cycle completion pulse from backing memory.
REQ-016 SHALL have port mem_rdata  input  WIDTH  read data, valid in the mem_ack cycle.

Function
REQ-017 SHALL split the address as index = addr[2+log2(SETS)-1:2], tag = addr[WIDTH-1:2+log2(SETS)]; each line stores valid, tag and data.
REQ-018 SHALL implement FSM states IDLE, FILL, WRITE.
REQ-019 In IDLE, a read hit (valid and tag match) SHALL drive readData_M with line data combinationally, with stall_M=0 and zero added latency.
REQ-020 In IDLE, a read miss SHALL assert stall_M combinationally and transition to FILL.
REQ-021 In FILL, the block SHALL hold mem_req=1, mem_we=0 and mem_addr stable, and keep stall_M=1.
REQ-022 On mem_ack in FILL, the block SHALL write valid=1, tag and mem_rdata into the line and return to IDLE; the next cycle hits, so miss latency = cycles-to-ack + 1.
REQ-023 In IDLE, a store SHALL assert stall_M combinationally and transition to WRITE (write-through, no-write-allocate).
REQ-024 In WRITE, the block SHALL hold mem_req=1, mem_we=1 and mem_addr/mem_wdata stable, and keep stall_M=1.
REQ-025 On mem_ack in WRITE, the line data SHALL be updated if the line hit at request time, a miss SHALL leave the line unchanged, and the state SHALL return to IDLE with stall_M=0 in the following cycle.
REQ-026 memRead_M and memWrite_M both high SHALL be treated as a store.
REQ-027 With neither request high, mem_req=0, stall_M=0 and readData_M=0.
REQ-028 A mem_ack received in IDLE SHALL be ignored.
REQ-029 mem_req SHALL be driven only from registered FSM state (never combinationally from mem_ack).

Reset
REQ-030 rst at a clock edge SHALL clear all valid bits and force state to IDLE.
REQ-031 After reset, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0 and stall_M=0 until a new request arrives.
REQ-032 A reset during FILL/WRITE SHALL abandon the transaction without a line update; mem_req SHALL be low in the cycle after the reset edge.

Structure
REQ-033 A package cache_pkg SHALL hold the state enum (IDLE, FILL, WRITE), the default SETS, and the index/tag width constants.
REQ-034 Tag/valid/data storage SHALL be a sub-module data_cache_array (one write port, one combinational read port).

Verification
REQ-035 Reset, then load 0x100 with mem_ack after 2 cycles carrying 0xDEADBEEF -> stall_M high for 3 cycles, then readData_M=0xDEADBEEF, mem_req seen exactly once.
REQ-036 Repeat load 0x100 -> stall_M=0 and readData_M=0xDEADBEEF in the same cycle, mem_req stays 0.
REQ-037 Store 0x12345678 to 0x100 (hit) -> mem_req=mem_we=1, mem_addr=0x100 until ack; subsequent load 0x100 hits with 0x12345678.
REQ-038 Store to 0x200 (miss), then load 0x200 -> store leaves the line invalid and the load misses and issues a FILL.
REQ-039 Load 0x100 then 0x120 (same index, different tag) -> second load misses, evicts the line; reload of 0x100 misses again.
REQ-040 Assert rst mid-FILL before mem_ack -> mem_req low next cycle, load 0x100 afterwards misses (valid cleared), stray late mem_ack ignored.
